// File: rtl/shift_right_lanes_if.sv
// Request/result bundle for shift_right_lanes: one request channel (in_*) and
// one result channel (out_*), each a valid/ready pair.
interface shift_right_lanes_if #(
    parameter int LANE_W  = 12,
    parameter int LANES   = 8,
    parameter int SHIFT_W = 3
);
    localparam int W = LANE_W * LANES;

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in;
    logic [SHIFT_W-1:0] shift;
    logic [LANE_W-1:0]  fill;

    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out;
    logic               out_err;

    modport master (
        output in_valid, in, shift, fill, out_ready,
        input  in_ready, out_valid, out, out_err
    );

    modport slave (
        input  in_valid, in, shift, fill, out_ready,
        output in_ready, out_valid, out, out_err
    );
endinterface

// File: rtl/shift_right_lanes.sv
// Lane-granular right shifter: shifts a word right by N lanes, one lane per
// clock, inserting a fill lane at the top each step.
module shift_right_lanes #(
    parameter int LANE_W  = 12,
    parameter int LANES   = 8,
    parameter int SHIFT_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_right_lanes_if.slave  bus,
    output logic [1:0]          state_dbg
);
    localparam int W = LANE_W * LANES;
    // Largest legal distance; the two largest codes are reserved as errors.
    localparam int MAX_SHIFT = LANES - 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [W-1:0]       data;
    logic [LANE_W-1:0]  fill_reg;
    logic [SHIFT_W-1:0] count;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               out_err_q;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high. The request side is ready only in IDLE; the result stays valid
    // and unchanged in DONE until out_ready is seen high at an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data        <= '0;
            fill_reg    <= '0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data       <= bus.in;
                        fill_reg   <= bus.fill;
                        count      <= bus.shift;
                        in_ready_q <= 1'b0;
                        if (bus.shift == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b0;
                        end else if (bus.shift > SHIFT_W'(MAX_SHIFT)) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                        end else begin
                            state     <= SHIFT;
                            out_err_q <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    data  <= {fill_reg, data[W-1:LANE_W]};
                    count <= count - SHIFT_W'(1);
                    if (count == SHIFT_W'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_err   = out_err_q;
    assign bus.out       = data;
    assign state_dbg     = state;
endmodule

// File: tb/tb_shift_right_lanes.sv
// Directed and randomized checks of shift_right_lanes against a lane-indexing
// reference model with a cycle-accurate expected-result queue.
module tb_shift_right_lanes;
    localparam int W = 96;

    logic clk;
    logic rst_n;
    logic [1:0] state_dbg;

    shift_right_lanes_if sif ();

    shift_right_lanes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (sif.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Result lane i comes from input lane i+N when that lane exists, else fill.
    function automatic logic [W:0] model(input logic [W-1:0] d, input int s, input logic [11:0] f);
        logic [W-1:0] r;
        r = '0;
        if (s == 0) return {1'b0, d};
        if (s > 5) return {1'b1, d};
        for (int i = 0; i < 8; i++)
            r[i*12 +: 12] = (i + s < 8) ? d[(i+s)*12 +: 12] : f;
        return {1'b0, r};
    endfunction

    // Edges after the accept edge before out_valid shows: one per lane shifted.
    function automatic int exp_lat(input int s);
        return (s >= 1 && s <= 5) ? s : 0;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [W:0] exp_q[$];
    int         ncyc    = 0;
    int         due     = 0;
    bit         pending = 1'b0;
    int         n_done  = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending = 1'b0;
            exp_q.delete();
        end else begin
            if (!pending) begin
                check_b("idle_in_ready", sif.in_ready, 1'b1);
                check_b("idle_out_valid", sif.out_valid, 1'b0);
                if (sif.in_valid) begin
                    exp_q.push_back(model(sif.in, int'(sif.shift), sif.fill));
                    due     = ncyc + 1 + exp_lat(int'(sif.shift));
                    pending = 1'b1;
                end
            end else if (ncyc < due) begin
                check_b("busy_in_ready", sif.in_ready, 1'b0);
                check_b("busy_out_valid", sif.out_valid, 1'b0);
            end else begin
                check_b("done_out_valid", sif.out_valid, 1'b1);
                check_b("done_in_ready", sif.in_ready, 1'b0);
                if (exp_q.size() > 0) begin
                    check_w("done_out", sif.out, exp_q[0][W-1:0]);
                    check_b("done_out_err", sif.out_err, exp_q[0][W]);
                end
                if (sif.out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    pending = 1'b0;
                    n_done++;
                end
            end
            ncyc++;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge with the DUT idle; runs one request to
    // completion, holding out_ready low for 'hold' cycles once the result shows.
    task automatic run_req(input logic [W-1:0] d, input logic [2:0] s, input logic [11:0] f,
                           input int hold, output logic [W-1:0] res, output logic err,
                           output int lat);
        sif.in       = d;
        sif.shift    = s;
        sif.fill     = f;
        sif.in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the request inputs right after accept; they must not matter.
        sif.in_valid = 1'b0;
        sif.in       = {$urandom, $urandom, $urandom};
        sif.shift    = 3'($urandom_range(0, 7));
        sif.fill     = 12'($urandom);
        lat = 0;
        while (!sif.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = sif.out;
        err = sif.out_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_w("hold_out", sif.out, res);
            check_b("hold_in_ready", sif.in_ready, 1'b0);
            check_b("hold_out_valid", sif.out_valid, 1'b1);
        end
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.out_ready = 1'b0;
        check_b("release_out_valid", sif.out_valid, 1'b0);
        check_b("release_in_ready", sif.in_ready, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] res;
    logic         err;
    int           lat;
    logic [W-1:0] v033;

    initial begin
        rst_n         = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in        = '0;
        sif.shift     = '0;
        sif.fill      = '0;
        sif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_w("reset_out", sif.out, '0);
        check_b("reset_out_valid", sif.out_valid, 1'b0);
        check_b("reset_out_err", sif.out_err, 1'b0);
        check_b("reset_in_ready", sif.in_ready, 1'b1);

        // Pin the model against hand-derived results.
        v033 = 96'h0123456789ABCDEF01234567;
        check_w("model_shift2", model(v033, 2, 12'hFFF)[W-1:0], 96'hFFFFFF0123456789ABCDEF01);
        check_w("model_shift5", model({W{1'b1}}, 5, 12'hA5A)[W-1:0],
                {{5{12'hA5A}}, 36'hFFFFFFFFF});
        check_b("model_err7", model(v033, 7, 12'h000)[W], 1'b1);

        // First accept on the first edge after reset release.
        rst_n = 1'b1;
        run_req(v033, 3'd2, 12'hFFF, 0, res, err, lat);
        check_w("s2_out", res, 96'hFFFFFF0123456789ABCDEF01);
        check_b("s2_err", err, 1'b0);
        check_i("s2_lat", lat, 2);

        run_req(96'h1, 3'd0, 12'hABC, 0, res, err, lat);
        check_w("s0_out", res, 96'h1);
        check_b("s0_err", err, 1'b0);
        check_i("s0_lat", lat, 0);

        run_req(96'hDEADBEEFCAFEF00D12345678, 3'd6, 12'h111, 0, res, err, lat);
        check_w("s6_out", res, 96'hDEADBEEFCAFEF00D12345678);
        check_b("s6_err", err, 1'b1);
        check_i("s6_lat", lat, 0);

        run_req(96'h0F0E0D0C0B0A090807060504, 3'd7, 12'h222, 0, res, err, lat);
        check_w("s7_out", res, 96'h0F0E0D0C0B0A090807060504);
        check_b("s7_err", err, 1'b1);
        check_i("s7_lat", lat, 0);

        // Long backpressure on the maximum legal distance.
        run_req({W{1'b1}}, 3'd5, 12'hA5A, 10, res, err, lat);
        check_w("s5_out", res, 96'hA5AA5AA5AA5AA5AFFFFFFFFF);
        check_b("s5_err", err, 1'b0);
        check_i("s5_lat", lat, 5);

        // Abort mid-shift with an asynchronous reset pulse.
        sif.in       = 96'h123456789ABCDEF012345678;
        sif.shift    = 3'd4;
        sif.fill     = 12'h777;
        sif.in_valid = 1'b1;
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_w("abort_out", sif.out, '0);
        check_b("abort_out_valid", sif.out_valid, 1'b0);
        check_b("abort_out_err", sif.out_err, 1'b0);
        check_b("abort_in_ready", sif.in_ready, 1'b1);
        #1 rst_n = 1'b1;
        run_req(96'hAAABBBCCCDDDEEEFFF111222, 3'd1, 12'h345, 2, res, err, lat);
        check_w("s1_out", res, 96'h345AAABBBCCCDDDEEEFFF111);
        check_b("s1_err", err, 1'b0);
        check_i("s1_lat", lat, 1);

        // Randomized back-to-back traffic with random backpressure.
        n_done = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            sif.in_valid  = ($urandom_range(0, 3) != 0);
            sif.in        = {$urandom, $urandom, $urandom};
            sif.shift     = 3'($urandom_range(0, 7));
            sif.fill      = 12'($urandom);
            sif.out_ready = ($urandom_range(0, 2) != 0);
        end
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        for (int c = 0; c < 20 && pending; c++) @(posedge clk);
        @(negedge clk);
        check_b("drain_idle", pending, 1'b0);
        check_i("drain_queue", exp_q.size(), 0);
        check_b("random_traffic_seen", (n_done >= 20), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end
endmodule
